sm3_pad_core: RTL and testbench

SM3_PAD_CORE -- requirements
Module: sm3_pad_core

---
 rtl/sm3_pkg.sv | 16 +
 rtl/sm3_len_cntr.sv | 27 ++
 rtl/sm3_pad_core.sv | 111 +++++++++++
 tb/tb_sm3_pad_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pkg.sv
// sm3_pkg: shared types and constants for the SM3 message padder.
package sm3_pkg;

   typedef enum logic [2:0] {IDLE, MSG, PAD1, ZERO, LEN_HI, LEN_LO} sm3_pad_st_e;

   localparam int          SM3_BLK_WORDS  = 16;
   localparam logic [31:0] SM3_PAD_WORD   = 32'h8000_0000;
   localparam logic [3:0]  SM3_LEN_HI_IDX = 4'd14;
   localparam logic [3:0]  SM3_LEN_LO_IDX = 4'd15;

   // Valid-byte mask is MSB-contiguous, so the byte count is its popcount.
   function automatic logic [2:0] vb_to_k(input logic [3:0] vb);
      return 3'(vb[3]) + 3'(vb[2]) + 3'(vb[1]) + 3'(vb[0]);
   endfunction

endpackage

// File: rtl/sm3_len_cntr.sv
// sm3_len_cntr: message bit-length accumulator, wraps modulo 2^LEN_W.
module sm3_len_cntr #(
   parameter int LEN_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             add32_i,
   input  logic             add8k_i,
   input  logic [2:0]       k_i,
   output logic [LEN_W-1:0] len_o
);

   logic [LEN_W-1:0] len_q, len_d;

   always_comb
      len_d = clr_i ? '0
                    : len_q + (add32_i ? LEN_W'(32) : '0) + (add8k_i ? LEN_W'({k_i, 3'b000}) : '0);

   always_ff @(posedge clk) begin
      if (!rst_n) len_q <= '0;
      else        len_q <= len_d;
   end

   assign len_o = len_q;

endmodule

// File: rtl/sm3_pad_core.sv
// sm3_pad_core: SM3 message padder; streams message words out as padded 512-bit
// blocks with the 0x80 marker, zero fill and the 64-bit bit-length trailer.
module sm3_pad_core
   import sm3_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] msg_inpt_d_i,
   input  logic        msg_inpt_vld_i,
   input  logic        msg_inpt_lst_i,
   input  logic [3:0]  msg_inpt_vld_byte_i,
   output logic        msg_inpt_rdy_o,
   output logic [31:0] pad_otpt_d_o,
   output logic        pad_otpt_vld_o,
   output logic        pad_otpt_lst_o,
   input  logic        pad_otpt_rdy_i
);

   localparam int IDX_W = $clog2(SM3_BLK_WORDS);

   sm3_pad_st_e      st_q, st_d, pad_nxt;
   logic [IDX_W-1:0] idx_q, idx_d, li;
   logic [31:0]      d_q, d_d, mask;
   logic             vld_q, vld_d, lst_q, lst_d;
   logic             ld, hs, acc, full;
   logic [2:0]       k;
   logic [LEN_W-1:0] len;

   assign ld             = !vld_q || pad_otpt_rdy_i;
   assign hs             = vld_q && pad_otpt_rdy_i;
   assign msg_inpt_rdy_o = rst_n && ld && (st_q == IDLE || st_q == MSG);
   assign acc            = msg_inpt_vld_i && msg_inpt_rdy_o;
   assign k              = vb_to_k(msg_inpt_vld_byte_i);
   assign full           = (k == 3'd4);
   assign mask           = {{8{msg_inpt_vld_byte_i[3]}}, {8{msg_inpt_vld_byte_i[2]}},
                            {8{msg_inpt_vld_byte_i[1]}}, {8{msg_inpt_vld_byte_i[0]}}};
   // Index of the word being loaded now: the held word leaves on a handshake.
   assign li             = idx_q + IDX_W'(vld_q);
   assign pad_nxt        = (li + 1'b1 == SM3_LEN_HI_IDX) ? LEN_HI : ZERO;

   sm3_len_cntr #(.LEN_W(LEN_W)) u_len (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (hs && lst_q),
      .add32_i (acc && !msg_inpt_lst_i),
      .add8k_i (acc && msg_inpt_lst_i),
      .k_i     (k),
      .len_o   (len)
   );

   always_comb begin
      st_d  = st_q;
      d_d   = d_q;
      vld_d = vld_q;
      lst_d = lst_q;
      idx_d = idx_q + IDX_W'(hs);
      if (ld) begin
         lst_d = 1'b0;
         case (st_q)
            IDLE, MSG: begin
               vld_d = acc;
               if (acc) begin
                  // A full last word gets a zero marker shift, so it passes unchanged.
                  d_d  = msg_inpt_lst_i ? (msg_inpt_d_i & mask) | (SM3_PAD_WORD >> {k, 3'b000})
                                        : msg_inpt_d_i;
                  st_d = !msg_inpt_lst_i ? MSG : full ? PAD1 : pad_nxt;
               end
            end
            PAD1, ZERO: begin
               vld_d = 1'b1;
               d_d   = (st_q == PAD1) ? SM3_PAD_WORD : '0;
               st_d  = pad_nxt;
            end
            LEN_HI: begin
               vld_d = 1'b1;
               d_d   = len[LEN_W-1:32];
               st_d  = LEN_LO;
            end
            default: begin
               vld_d = !lst_q;
               lst_d = !lst_q && (li == SM3_LEN_LO_IDX);
               d_d   = lst_q ? d_q : len[31:0];
               st_d  = lst_q ? IDLE : LEN_LO;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q  <= IDLE;
         idx_q <= '0;
         d_q   <= '0;
         vld_q <= 1'b0;
         lst_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         idx_q <= idx_d;
         d_q   <= d_d;
         vld_q <= vld_d;
         lst_q <= lst_d;
      end
   end

   assign pad_otpt_d_o   = d_q;
   assign pad_otpt_vld_o = vld_q;
   assign pad_otpt_lst_o = lst_q;

endmodule

// File: tb/tb_sm3_pad_core.sv
// tb_sm3_pad_core: table-driven messages against a byte-level padding model,
// plus back-to-back and mid-message reset sequences.
module tb_sm3_pad_core;

   typedef struct {
      int          n;
      logic [31:0] w0;
      logic [31:0] inc;
      logic [3:0]  vb;
      int          pct;
      int          nout;
   } vec_t;
   typedef struct {
      logic [31:0] d;
      logic        lst;
      logic [3:0]  vb;
   } in_t;
   typedef struct {
      logic [31:0] d;
      logic        lst;
   } exp_t;

   logic        clk, rst_n;
   logic [31:0] msg_d, out_d;
   logic        msg_vld, msg_lst, msg_rdy;
   logic [3:0]  msg_vb;
   logic        out_vld, out_lst, out_rdy;

   in_t  in_q[$];
   exp_t exp_q[$];
   int   n_cmp = 0, n_err = 0, out_cnt = 0, rdy_pct = 100;
   logic acc_n = 1'b0, stall_prev = 1'b0;
   logic [31:0] sv_d;
   logic        sv_lst;

   sm3_pad_core #(.LEN_W(64)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .msg_inpt_d_i        (msg_d),
      .msg_inpt_vld_i      (msg_vld),
      .msg_inpt_lst_i      (msg_lst),
      .msg_inpt_vld_byte_i (msg_vb),
      .msg_inpt_rdy_o      (msg_rdy),
      .pad_otpt_d_o        (out_d),
      .pad_otpt_vld_o      (out_vld),
      .pad_otpt_lst_o      (out_lst),
      .pad_otpt_rdy_i      (out_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Reference: byte stream, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
   task automatic load_msg(input vec_t v);
      logic [7:0]  bq[$];
      logic [31:0] w;
      logic [63:0] bits;
      int          k, nb, nw;
      k = (v.vb == 4'hF) ? 4 : (v.vb == 4'hE) ? 3 : (v.vb == 4'hC) ? 2 : 1;
      for (int i = 0; i < v.n; i++) begin
         w  = v.w0 + v.inc * 32'(i);
         nb = (i == v.n - 1) ? k : 4;
         in_q.push_back('{w, i == v.n - 1, (i == v.n - 1) ? v.vb : 4'($urandom_range(0, 15))});
         for (int b = 0; b < nb; b++) bq.push_back(w[31 - 8 * b -: 8]);
      end
      bits = 64'(bq.size()) * 64'd8;
      bq.push_back(8'h80);
      while (bq.size() % 64 != 56) bq.push_back(8'h00);
      for (int b = 7; b >= 0; b--) bq.push_back(bits[8 * b +: 8]);
      nw = bq.size() / 4;
      for (int i = 0; i < nw; i++)
         exp_q.push_back('{{bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]}, i == nw - 1});
   endtask

   task automatic drain(input int nout, input string nm);
      int t = 0;
      while ((exp_q.size() > 0 || in_q.size() > 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: %0d words still expected", nm, exp_q.size());
         exp_q.delete();
         in_q.delete();
      end
      chk(nm, 64'(out_cnt), 64'(nout));
   endtask

   // Driver and ready generator, updated just after each rising edge.
   initial begin
      msg_vld = 1'b0; msg_lst = 1'b0; msg_vb = 4'h0; msg_d = '0; out_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (acc_n && in_q.size() > 0) void'(in_q.pop_front());
         out_rdy = ($urandom_range(0, 99) < rdy_pct);
         if (rst_n && in_q.size() > 0) begin
            msg_vld = 1'b1; msg_d = in_q[0].d; msg_lst = in_q[0].lst; msg_vb = in_q[0].vb;
         end else begin
            msg_vld = 1'b0; msg_d = $urandom; msg_lst = 1'b0; msg_vb = 4'h0;
         end
      end
   end

   // Monitor: sampled on the falling edge, ahead of the edge that completes a handshake.
   initial forever begin
      exp_t e;
      @(negedge clk);
      acc_n = msg_vld && msg_rdy && rst_n;
      if (rst_n && stall_prev) begin
         chk("stall_vld", 64'(out_vld), 64'd1);
         chk("stall_data", {31'd0, out_lst, out_d}, {31'd0, sv_lst, sv_d});
      end
      if (rst_n && out_vld && !out_rdy) chk("stall_no_accept", 64'(msg_rdy), 64'd0);
      if (rst_n && out_vld && out_rdy) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_word: got %h lst %b, want none", out_d, out_lst);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("word%0d", out_cnt), {31'd0, out_lst, out_d}, {31'd0, e.lst, e.d});
         end
         out_cnt++;
      end
      stall_prev = rst_n && out_vld && !out_rdy;
      sv_d   = out_d;
      sv_lst = out_lst;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[11];
      vec_t abc, xyz;
      int   t;
      vecs[0]  = '{1,  32'h61626300, 32'd0,        4'b1110, 100, 16};
      vecs[1]  = '{16, 32'h61626364, 32'd0,        4'b1111, 100, 32};
      vecs[2]  = '{14, 32'h01020304, 32'h01010101, 4'b1111, 100, 32};
      vecs[3]  = '{1,  32'h61626300, 32'd0,        4'b1110, 50,  16};
      vecs[4]  = '{13, 32'hA5A50000, 32'd1,        4'b1000, 70,  16};
      vecs[5]  = '{14, 32'h11223344, 32'd3,        4'b1100, 100, 16};
      vecs[6]  = '{15, 32'hDEADBEEF, 32'd7,        4'b1110, 60,  32};
      vecs[7]  = '{16, 32'hCAFEF00D, 32'd1,        4'b1000, 100, 32};
      vecs[8]  = '{13, 32'h00000000, 32'h10,       4'b1111, 80,  16};
      vecs[9]  = '{1,  32'h12345678, 32'd0,        4'b1111, 100, 16};
      vecs[10] = '{20, 32'h00000009, 32'd5,        4'b1100, 50,  32};
      abc = vecs[0];
      xyz = '{1, 32'h78797A00, 32'd0, 4'b1110, 100, 16};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vld", 64'(out_vld), 64'd0);
      chk("rst_lst", 64'(out_lst), 64'd0);
      chk("rst_data", 64'(out_d), 64'd0);
      chk("rst_rdy", 64'(msg_rdy), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         rdy_pct = vecs[i].pct;
         out_cnt = 0;
         load_msg(vecs[i]);
         drain(vecs[i].nout, $sformatf("vec%0d_count", i));
      end

      // Back-to-back messages: second first word accepted right after the LEN_LO handshake.
      rdy_pct = 100;
      out_cnt = 0;
      load_msg(abc);
      load_msg(xyz);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(out_vld && out_lst) && t < 200);
      chk("b2b_lst_seen", 64'(out_vld && out_lst), 64'd1);
      @(negedge clk);
      chk("b2b_rdy", 64'(msg_rdy && msg_vld), 64'd1);
      drain(32, "b2b_count");

      // Reset while word 7 of a two-block message is presented.
      out_cnt = 0;
      load_msg(vecs[1]);
      t = 0;
      while (out_cnt < 7 && t < 200) begin
         @(posedge clk);
         t++;
      end
      chk("mid_reached", 64'(out_cnt), 64'd7);
      #2 rst_n = 1'b0;
      in_q.delete();
      exp_q.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_vld", 64'(out_vld), 64'd0);
      chk("mid_rst_lst", 64'(out_lst), 64'd0);
      repeat (3) @(negedge clk);
      chk("mid_quiet", 64'(out_vld), 64'd0);
      out_cnt = 0;
      load_msg(abc);
      drain(16, "post_rst_count");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
